// File: rtl/ssd_reader_pkg.sv
// Shared constants and types for the 7-segment reader: legal active-low
// segment patterns (bit0=a .. bit6=g) and the settle FSM encoding.
package ssd_reader_pkg;

    typedef enum logic {
        HOLD   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index is the hex digit the pattern represents.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational map from an active-low segment pattern to its hex digit.
module seg_pattern_lookup
    import ssd_reader_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       legal
);

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        digit = '0;
        legal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_PATTERNS[i]) begin
                digit = 4'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssd_reader.sv
// Debounces an asynchronous 7-segment bus and reports the stable hex digit,
// blank display, or illegal patterns once a pattern holds STABLE_CYCLES.
module ssd_reader
    import ssd_reader_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    output logic       seg_err,
    output logic       blank
);

    localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

    logic [6:0]  s1, s2, cand;
    logic [15:0] cnt;
    state_t      state, state_next;
    logic        load_cand, cnt_inc, classify;
    logic [3:0]  cand_digit;
    logic        cand_legal;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= SEG_BLANK;
            s2 <= SEG_BLANK;
        end else begin
            s1 <= seg_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HOLD;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HOLD:    if (s2 != cand) state_next = SETTLE;
            SETTLE:  if (s2 == cand && cnt == CNT_LAST) state_next = HOLD;
            default: state_next = HOLD;
        endcase
    end

    // Any difference from the candidate restarts the count, in either state.
    always_comb begin
        load_cand = (s2 != cand);
        cnt_inc   = (state == SETTLE) && !load_cand && (cnt != CNT_LAST);
        classify  = (state == SETTLE) && !load_cand && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand <= SEG_BLANK;
            cnt  <= '0;
        end else if (load_cand) begin
            cand <= s2;
            cnt  <= '0;
        end else if (cnt_inc) begin
            cnt  <= cnt + 16'd1;
        end
    end

    seg_pattern_lookup u_lookup (
        .pattern (cand),
        .digit   (cand_digit),
        .legal   (cand_legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_out   <= '0;
            digit_valid <= 1'b0;
            seg_err     <= 1'b0;
            blank       <= 1'b1;
        end else begin
            digit_valid <= 1'b0;
            seg_err     <= 1'b0;
            if (classify) begin
                if (cand_legal) begin
                    // Leaving blank re-announces the digit even if it is unchanged.
                    if (cand_digit != digit_out || blank) begin
                        digit_out   <= cand_digit;
                        digit_valid <= 1'b1;
                        blank       <= 1'b0;
                    end
                end else if (cand == SEG_BLANK) begin
                    blank <= 1'b1;
                end else begin
                    seg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ssd_reader.md
SSD_READER -- requirements
Module: ssd_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 50000, meaning consecutive clk cycles a synchronized pattern must hold before classification (legal range 1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port seg_in  input  7  segment pattern from an external 7-segment driver, asynchronous to clk; bit0=a ... bit6=g, active-low (0 = segment lit).
REQ-005 SHALL have port digit_out  output  4  last accepted hex digit, registered.
REQ-006 SHALL have port digit_valid  output  1  one-cycle pulse when digit_out takes a new value.
REQ-007 SHALL have port seg_err  output  1  one-cycle pulse when a stable pattern matches no legal pattern.
REQ-008 SHALL have port blank  output  1  level; high while the last stable pattern is 7'h7F (all segments dark).

Function
REQ-009 SHALL recognise exactly these legal patterns (digit:hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:18 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-010 SHALL pass seg_in through a two-flop synchronizer (s1, s2) before any other use.
REQ-011 SHALL keep a candidate register cand and a 16-bit stability counter cnt; FSM states HOLD and SETTLE.
REQ-012 HOLD: when s2 != cand, load cand<=s2, cnt<=0, go to SETTLE; otherwise remain.
REQ-013 SETTLE: if s2 != cand, reload cand<=s2, cnt<=0, stay in SETTLE (glitch restarts the count).
REQ-014 SETTLE: if s2 == cand and cnt < STABLE_CYCLES-1, increment cnt.
REQ-015 SETTLE: if s2 == cand and cnt == STABLE_CYCLES-1, classify cand at that edge and return to HOLD.
REQ-016 Classification, legal pattern with digit != digit_out or blank high: digit_out<=digit, digit_valid pulse, blank<=0.
REQ-017 Classification, legal pattern equal to current digit_out with blank low: no output change, no pulse.
REQ-018 Classification, 7'h7F: blank<=1, digit_out unchanged, no pulse.
REQ-019 Classification, any other pattern: seg_err pulse, digit_out and blank unchanged.
REQ-020 Latency: a seg_in change first sampled at edge 1 and held SHALL update outputs at edge STABLE_CYCLES+3.
REQ-021 digit_valid and seg_err SHALL never be high in the same cycle; each is high for exactly one cycle per event.
REQ-022 cnt SHALL never exceed STABLE_CYCLES-1 (no wrap-around).

Reset
REQ-023 On reset low, asynchronously: s1, s2, cand <= 7'h7F; cnt<=0; state<=HOLD; digit_out<=0; digit_valid<=0; seg_err<=0; blank<=1.
REQ-024 Reset asserted mid-SETTLE SHALL discard the pending candidate with no pulse emitted.

Structure
REQ-025 The sixteen legal pattern constants and the blank constant SHALL live in a shared header, ssd_patterns.vh, used by both ssd_reader and seven_seg_decoder benches.
REQ-026 Pattern-to-digit mapping SHALL be a combinational sub-module seg_pattern_lookup (in: 7-bit pattern; out: 4-bit digit, 1-bit legal).

Verification (STABLE_CYCLES=4)
REQ-027 Reset release, seg_in=7'h7F -> digit_out=0, blank=1, no pulses for 20 cycles.
REQ-028 seg_in 7F->24 held -> digit_valid pulse with digit_out=2 at edge 7 after first sample, blank=0.
REQ-029 seg_in 24->30, glitch back to 24 for 1 cycle at count 2, then 30 held -> single digit_valid, digit_out=3, counted from the last change.
REQ-030 seg_in 30->7F->30 (each held 10 cycles) -> blank pulses high then low; digit_valid pulse on return to 3 even though digit_out is unchanged.
REQ-031 seg_in=7'h55 held -> one seg_err pulse, digit_out unchanged; all 16 legal patterns swept -> digit_out 0..F in order.
REQ-032 Reset asserted at cnt=2 during 30->12 settle -> no pulse, digit_out=0, blank=1 after release.
